mult_share_sched: RTL

- Time-shares one combinational 4x4 array multiplier (partial-product tree plus prefix adder) among NREQ requesters.
- Round-robin arbitration, valid/ready request and response handshakes, registered product output tagged with requester ID.
- Sits between the requester clients and the multiplier instance; it owns the multiplier's operand inputs.

---
 rtl/mult_share_pkg.sv | 17 +
 rtl/mult_share_sched_if.sv | 30 +++
 rtl/mult_share_sched_rr_arbiter.sv | 50 +++++
 rtl/mult_share_sched.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared constants, FSM state type and ID-width helper for mult_share_sched.
// Imported by the interface, the arbiter and the scheduler top.
package mult_share_pkg;

   localparam int W_DEF    = 4;
   localparam int NREQ_DEF = 4;

   typedef enum logic {
      EMPTY,
      FULL
   } state_t;

   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// Request/response handshake bundle between clients and mult_share_sched.
// master = client side (req_valid/x/y, rsp_ready); slave = scheduler side.
interface mult_share_sched_if #(
   parameter int W    = mult_share_pkg::W_DEF,
   parameter int NREQ = mult_share_pkg::NREQ_DEF
);
   import mult_share_pkg::*;

   localparam int IDW = id_width(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_x;
   logic [NREQ*W-1:0] req_y;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [2*W-1:0]    rsp_prod;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_prod
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_prod
   );

endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin arbiter: req -> one-hot gnt, binary idx, hit; holds pointer.
// Ports: clk, rst, req, advance (handshake strobe), gnt, idx, hit.
module rr_arbiter
   import mult_share_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   localparam int IDW = id_width(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            hit
);

   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] nxt;

   // ptr_q is the last granted index; search begins one past it.
   assign nxt = (ptr_q == IDW'(NREQ - 1)) ? '0 : ptr_q + 1'b1;

   // With no request, idx rests on ptr+1 so the operand mux is stable.
   always_comb begin
      int j;
      j   = 0;
      hit = 1'b0;
      idx = nxt;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_q) + 1 + k) % NREQ;
         if (!hit && req[j]) begin
            hit = 1'b1;
            idx = IDW'(j);
         end
      end
   end

   assign gnt = hit ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : '0;

   // Reset to NREQ-1 so requester 0 has top priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= IDW'(NREQ - 1);
      end else if (advance) begin
         ptr_q <= idx;
      end
   end

endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one external combinational multiplier among NREQ clients.
// Ports: clk, rst (sync, high), bus (slave), mul_x/mul_y/mul_o, busy.
// Option MULT_SHARE_OPREG_EN adds an operand register stage (latency 2).
module mult_share_sched
   import mult_share_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int NREQ = NREQ_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_share_sched_if.slave    bus,
   output logic [W-1:0]         mul_x,
   output logic [W-1:0]         mul_y,
   input  logic [2*W-1:0]       mul_o,
   output logic                 busy
);

   localparam int IDW = id_width(NREQ);

   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  win;
   logic            hit;
   logic            acc;
   logic            drain_ok;
   logic            rsp_load;
   logic [IDW-1:0]  load_id;
   state_t          state_q;
   state_t          state_d;
   logic [2*W-1:0]  prod_q;
   logic [IDW-1:0]  id_q;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.req_valid),
      .advance (acc),
      .gnt     (gnt),
      .idx     (win),
      .hit     (hit)
   );

   // Response register can take a new product this cycle.
   assign drain_ok = (state_q == EMPTY) || bus.rsp_ready;

`ifdef MULT_SHARE_OPREG_EN
   logic           op_vld_q;
   logic [W-1:0]   op_x_q;
   logic [W-1:0]   op_y_q;
   logic [IDW-1:0] op_id_q;
   logic           op_can;

   // Operand stage frees up when empty or when it moves on this cycle.
   assign op_can        = !op_vld_q || drain_ok;
   assign acc           = hit && op_can;
   assign bus.req_ready = op_can ? gnt : '0;
   assign rsp_load      = op_vld_q && drain_ok;
   assign load_id       = op_id_q;
   assign mul_x         = op_x_q;
   assign mul_y         = op_y_q;
   assign busy          = bus.rsp_valid || op_vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         op_vld_q <= 1'b0;
         op_x_q   <= '0;
         op_y_q   <= '0;
         op_id_q  <= '0;
      end else begin
         if (op_can) begin
            op_vld_q <= acc;
         end
         if (acc) begin
            op_x_q  <= bus.req_x[win*W +: W];
            op_y_q  <= bus.req_y[win*W +: W];
            op_id_q <= win;
         end
      end
   end
`else
   assign acc           = hit && drain_ok;
   assign bus.req_ready = drain_ok ? gnt : '0;
   assign rsp_load      = acc;
   assign load_id       = win;
   assign mul_x         = bus.req_x[win*W +: W];
   assign mul_y         = bus.req_y[win*W +: W];
   assign busy          = bus.rsp_valid;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (rsp_load) state_d = FULL;
         end
         FULL: begin
            if (bus.rsp_ready && !rsp_load) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         prod_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         if (rsp_load) begin
            prod_q <= mul_o;
            id_q   <= load_id;
         end
      end
   end

   assign bus.rsp_valid = (state_q == FULL);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_prod  = prod_q;

endmodule
